imem_load_ctrl: RTL

Controller that owns the single address port of a writable instruction memory and sequences it between a program loader stream and core instruction fetch. After reset it holds the core off, accepts a program image word-by-word, pads the rest of memory with NOPs, then releases the core and passes fetch addresses through. It sits between the boot/debug loader, the core fetch stage and the instruction memory array.

---
 rtl/imem_load_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/imem_load_ctrl.sv
// Instruction-memory port arbiter: streams a program image from the loader,
// pads the rest of memory with NOPs, then hands the address port to core fetch.
module imem_load_ctrl #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  input  logic [31:0]       core_pc,
  output logic [31:0]       core_instr,
  output logic              core_hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILL = 2'd2,
    RUN  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_clamped;
  logic              start_ok;
  logic              accept;
  logic              last_word;
  logic              fill_end;
  logic              fetch_bad;

  assign len_clamped = (load_len > DEPTH) ? DEPTH : load_len;
  assign start_ok    = start && (state == IDLE || state == RUN);
  assign accept      = (state == LOAD) && ld_valid;
  assign last_word   = accept && (({1'b0, cnt} + (ADDR_W+1)'(1)) == len_q);
  assign fill_end    = (state == FILL) && (cnt == '1);
  assign fetch_bad   = (core_pc[1:0] != 2'b00) || (core_pc[31:ADDR_W+2] != '0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, RUN: if (start) state_nxt = (len_clamped == '0) ? FILL : LOAD;
      LOAD:      if (last_word) state_nxt = (len_q == DEPTH) ? RUN : FILL;
      FILL:      if (fill_end) state_nxt = RUN;
      default:   state_nxt = IDLE;
    endcase
  end

  // The counter after the last loaded word already equals len, so FILL
  // resumes from it directly; a full-depth load wraps it back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      len_q <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == RUN) && (state != RUN);
      if (start_ok) begin
        len_q <= len_clamped;
        cnt   <= '0;
      end else if (accept || state == FILL) begin
        cnt <= cnt + 1'b1;
      end
      if (start_ok)
        err <= 1'b0;
      else if (state == RUN && fetch_bad)
        err <= 1'b1;
    end
  end

  always_comb begin
    ld_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    mem_addr   = '0;
    core_hold  = 1'b1;
    core_instr = NOP_WORD;
    unique case (state)
      LOAD: begin
        ld_ready  = 1'b1;
        mem_addr  = cnt;
        mem_wdata = ld_data;
        mem_we    = ld_valid;
      end
      FILL: begin
        mem_addr  = cnt;
        mem_wdata = NOP_WORD;
        mem_we    = 1'b1;
      end
      RUN: begin
        core_hold  = 1'b0;
        mem_addr   = core_pc[ADDR_W+1:2];
        core_instr = mem_rdata;
      end
      default: ;
    endcase
  end

  assign busy = (state == LOAD) || (state == FILL);

endmodule
